mult_share_arbiter: RTL
=======================

# mult_share_arbiter

Round-robin scheduler that shares one pipelined signed Baugh-Wooley multiplier between `NUM_REQ` requesters. It accepts one operand pair at a time through per-requester valid/ready handshakes, issues the pair to the multiplier, and waits for `mul_out_valid`. It then returns the product, tagged with the requester ID, through a single response handshake with backpressure. It sits between the multiplier and the client blocks, and is the only driver of the multiplier's `in_valid`, `in_A` and `in_B`.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (2..8)
- `A_WIDTH`, 24, signed operand A width
- `B_WIDTH`, 24, signed operand B width
- `TIMEOUT`, 15, maximum cycles in WAIT before an error response is forced (must exceed multiplier latency)

Ports. Clock is `clk`. Reset is `reset`: synchronous, active-high.
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `req_valid`  in  NUM_REQ  per-requester request valid
- `req_ready`  out  NUM_REQ  per-requester accept, one-hot or zero
- `req_a`  in  NUM_REQ*A_WIDTH  flattened operand A; requester i occupies slice [i*A_WIDTH +: A_WIDTH]
- `req_b`  in  NUM_REQ*B_WIDTH  flattened operand B; same slicing with B_WIDTH
- `rsp_valid`  out  1  response valid
- `rsp_ready`  in  1  response accept
- `rsp_id`  out  ID_W = max(1, clog2(NUM_REQ))  requester index of the response
- `rsp_c`  out  A_WIDTH+B_WIDTH  signed product
- `rsp_error`  out  1  response produced by timeout; `rsp_c` = 0
- `busy`  out  1  high in any state other than IDLE
- `mul_in_valid`  out  1  pulse to the multiplier
- `mul_a`  out  A_WIDTH  operand A to the multiplier
- `mul_b`  out  B_WIDTH  operand B to the multiplier
- `mul_out_valid`  in  1  multiplier result strobe
- `mul_c`  in  A_WIDTH+B_WIDTH  multiplier result

## Operation
State machine:
- **IDLE**
  - Select grant g = first i with `req_valid[i]`, searching circularly from `ptr`.
  - Drive `req_ready[g]`=1 combinationally in the same cycle.
  - On that handshake, register `req_a[g]`, `req_b[g]` and g, then go to ISSUE.
  - If no request is valid, stay in IDLE.
- **ISSUE**
  - `mul_in_valid`=1 for exactly one cycle.
  - Clear the wait counter and go to WAIT.
- **WAIT**
  - Counter increments each cycle.
  - On `mul_out_valid`: capture `mul_c` into `rsp_c`, set `rsp_error`=0, go to RESP.
  - Else, if the counter reaches TIMEOUT: set `rsp_c`=0, `rsp_error`=1, go to RESP.
- **RESP**
  - `rsp_valid`=1.
  - On `rsp_ready`: set `ptr` = (g+1) mod NUM_REQ and go to IDLE.

Handshake and data rules:
- `mul_a` and `mul_b` are registered and held stable from ISSUE until the next grant. They are never combinational from `req_*`.
- `mul_out_valid` outside WAIT is ignored, including a stale result arriving after a timeout.
- `req_ready` is 0 in every state except IDLE. There is no bypass from RESP to a new grant.
- `rsp_id`, `rsp_c` and `rsp_error` stay stable while `rsp_valid`=1 and `rsp_ready`=0.
- Arithmetic is the multiplier's. The controller does no sign handling; the result width is A_WIDTH+B_WIDTH.

Reset:
- Reset from any state returns to IDLE with `ptr`=0.
- All outputs go to 0: `req_ready`, `rsp_valid`, `rsp_id`, `rsp_c`, `rsp_error`, `busy`, `mul_in_valid`, `mul_a`, `mul_b`.
- An in-flight operation is dropped. The multiplier shares this reset.

## Timing
- Request handshake in cycle t gives ISSUE (`mul_in_valid`) in cycle t+1.
- A `mul_out_valid` seen in WAIT cycle w gives `rsp_valid` at w+1.
- For 24x24 the multiplier latency L is 5 cycles after `mul_in_valid`. Request-to-response latency is therefore L+2 cycles.
- Minimum spacing between grants is L+3 cycles, with `rsp_ready` held high.
- Timeout response appears TIMEOUT+2 cycles after ISSUE.
- Fairness: each requester waits at most NUM_REQ-1 other grants.

## Structure
- Shared package `mult_pkg` holds:
  - the state enum (IDLE, ISSUE, WAIT, RESP);
  - an `ID_W` helper function;
  - the default widths.
- One sub-module, `rr_pick`: combinational circular priority picker. Inputs are the request vector and `ptr`; outputs are a one-hot grant and its index. It is reusable by other shared-resource schedulers.

## Test plan
Bench: NUM_REQ=4, A_WIDTH=B_WIDTH=8, real multiplier.
- **Single request:** req1 with a=-3, b=7 -> `rsp_id`=1, `rsp_c`=-21, `rsp_error`=0. Request-to-response latency is L+2.
- **Simultaneous requests:** all four valid from reset -> service order 0,1,2,3. Then assert req0 and req3 together -> req0 is served first, because `ptr` wrapped to 0.
- **Backpressure:** `rsp_ready` low for 10 cycles -> `rsp_valid` held, `rsp_c` stable, `req_ready`=0. No `mul_in_valid` until release.
- **Edge operands:** a=-128, b=-128 -> 16384. a=0, b=-5 -> 0. a=127, b=-128 -> -16256.
- **Timeout:** stub multiplier never asserts `mul_out_valid` -> `rsp_error`=1 and `rsp_c`=0, TIMEOUT+2 cycles after ISSUE. A late strobe after that is ignored.
- **Reset mid-WAIT:** assert reset -> the next cycle shows all outputs 0 and state IDLE. A new req2 is then served correctly with `ptr`=0.

Source files
------------

// File: rtl/mult_pkg.sv
// ---------------------------------------------------------------------------
// mult_pkg
// Shared definitions for the multiplier-sharing scheduler: default operand
// widths and timeout, the controller state encoding, and the requester-ID
// width helper used to size ID ports and round-robin pointers.
// ---------------------------------------------------------------------------
package mult_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_A_WIDTH = 24;
  localparam int DEF_B_WIDTH = 24;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  // Width of a requester index; a single requester still gets one bit.
  function automatic int id_w(input int n);
    if ($clog2(n) < 1) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational circular priority picker. Returns the first asserted request
// found when scanning upward from ptr and wrapping past N-1 back to 0.
// Ports:
//   req   in  N   request vector
//   ptr   in  IW  highest-priority position (must be < N)
//   grant out N   one-hot grant, zero when no request
//   idx   out IW  index of the granted position, zero when no request
// ---------------------------------------------------------------------------
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  int dist_s;
  int best_s;

  // Pick the requester with the smallest circular distance from ptr.
  always_comb begin
    grant  = '0;
    idx    = '0;
    best_s = N;
    dist_s = 0;
    for (int j = 0; j < N; j++) begin
      dist_s = (j + N - int'(ptr)) % N;
      if (req[j] && (dist_s < best_s)) begin
        best_s   = dist_s;
        grant    = '0;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end else begin
        best_s = best_s;
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// ---------------------------------------------------------------------------
// mult_share_arbiter
// Round-robin scheduler sharing one pipelined signed multiplier between
// NUM_REQ requesters. One operation is in flight at a time:
// IDLE (grant) -> ISSUE (strobe multiplier) -> WAIT (result or timeout)
// -> RESP (tagged response with backpressure) -> IDLE.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   req_valid/ready per-requester handshake (ready one-hot, IDLE only)
//   req_a, req_b    flattened operands, requester i at [i*W +: W]
//   rsp_valid/ready response handshake
//   rsp_id, rsp_c   requester index and product of the response
//   rsp_error       response forced by timeout (rsp_c is then zero)
//   busy            controller not in IDLE
//   mul_in_valid    one-cycle issue strobe to the multiplier
//   mul_a, mul_b    registered multiplier operands
//   mul_out_valid   multiplier result strobe, mul_c its result
// ---------------------------------------------------------------------------
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int A_WIDTH  = DEF_A_WIDTH,
  parameter int B_WIDTH  = DEF_B_WIDTH,
  parameter int TIMEOUT  = DEF_TIMEOUT,
  localparam int ID_W    = id_w(NUM_REQ),
  localparam int C_WIDTH = A_WIDTH + B_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*A_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*B_WIDTH-1:0] req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [C_WIDTH-1:0]         rsp_c,
  output logic                       rsp_error,
  output logic                       busy,
  output logic                       mul_in_valid,
  output logic [A_WIDTH-1:0]         mul_a,
  output logic [B_WIDTH-1:0]         mul_b,
  input  logic                       mul_out_valid,
  input  logic [C_WIDTH-1:0]         mul_c
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e             state_r;
  state_e             state_nxt_s;
  logic [ID_W-1:0]    ptr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [NUM_REQ-1:0] gnt_oh_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic               any_req_s;
  logic               timeout_s;
  logic [A_WIDTH-1:0] req_a_s [NUM_REQ];
  logic [B_WIDTH-1:0] req_b_s [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_a_s[i] = req_a[i*A_WIDTH +: A_WIDTH];
    assign req_b_s[i] = req_b[i*B_WIDTH +: B_WIDTH];
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_r),
    .grant (gnt_oh_s),
    .idx   (gnt_idx_s)
  );

  assign any_req_s = |req_valid;
  // Counter holds the number of WAIT cycles already spent.
  assign timeout_s = (cnt_r == CNT_W'(TIMEOUT));

  // Grant is offered combinationally, but only while idle and out of reset.
  always_comb begin
    req_ready = '0;
    if ((state_r == ST_IDLE) && !reset) begin
      req_ready = gnt_oh_s;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state decode; a result strobe outside WAIT is simply not looked at.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (any_req_s) begin
          state_nxt_s = ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_nxt_s = ST_WAIT;
      ST_WAIT: begin
        if (mul_out_valid || timeout_s) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register and state-decoded flags, registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      busy         <= 1'b0;
      mul_in_valid <= 1'b0;
      rsp_valid    <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      busy         <= (state_nxt_s != ST_IDLE);
      mul_in_valid <= (state_nxt_s == ST_ISSUE);
      rsp_valid    <= (state_nxt_s == ST_RESP);
    end
  end

  // Operand capture, wait counter, response data and round-robin pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r     <= '0;
      cnt_r     <= '0;
      mul_a     <= '0;
      mul_b     <= '0;
      rsp_id    <= '0;
      rsp_c     <= '0;
      rsp_error <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            mul_a  <= req_a_s[gnt_idx_s];
            mul_b  <= req_b_s[gnt_idx_s];
            rsp_id <= gnt_idx_s;
          end
        end
        ST_ISSUE: cnt_r <= '0;
        ST_WAIT: begin
          cnt_r <= cnt_r + CNT_W'(1);
          if (mul_out_valid) begin
            rsp_c     <= mul_c;
            rsp_error <= 1'b0;
          end else if (timeout_s) begin
            rsp_c     <= '0;
            rsp_error <= 1'b1;
          end
        end
        ST_RESP: begin
          // rsp_id still holds the granted index here.
          if (rsp_ready) begin
            if (rsp_id == ID_W'(NUM_REQ - 1)) begin
              ptr_r <= '0;
            end else begin
              ptr_r <= rsp_id + ID_W'(1);
            end
          end
        end
        default: ptr_r <= ptr_r;
      endcase
    end
  end

endmodule
